// File: rtl/lib_decmps_seq.sv
// Decomposes a vector into its set bits, issuing up to LANES one-hot vectors per beat
// under a valid/ready handshake on both sides.
module lib_decmps_seq #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned LANES   = 4,
   parameter int unsigned LSB_MSB = 0
) (
   input  logic                                clk,
   input  logic                                rstn,
   input  logic [WIDTH-1:0]                    vect_i,
   input  logic                                vld_i,
   output logic                                rdy_o,
   output logic [LANES-1:0][WIDTH-1:0]         onehot_o,
   output logic [LANES-1:0]                    lane_vld_o,
   output logic [$clog2(LANES+1)-1:0]          cnt_o,
   output logic                                vld_o,
   input  logic                                rdy_i,
   output logic                                last_o
);

   localparam int unsigned CW = $clog2(LANES + 1);
   localparam int unsigned PW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] residual_q, residual_d;
   logic [WIDTH-1:0] scan;
   logic [WIDTH-1:0] pick;
   logic [WIDTH-1:0] issued;
   logic [PW-1:0]    pop;

   function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         r[i] = v[WIDTH-1-i];
      end
      return r;
   endfunction

   // Peel off set bits one lane at a time; MSB-first order works on the mirrored vector.
   always_comb begin
      scan     = (LSB_MSB != 0) ? bit_rev(residual_q) : residual_q;
      pick     = '0;
      issued   = '0;
      onehot_o = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
         pick        = scan & (~scan + WIDTH'(1));
         scan        = scan & ~pick;
         onehot_o[k] = (LSB_MSB != 0) ? bit_rev(pick) : pick;
         issued      = issued | onehot_o[k];
      end
   end

   always_comb begin
      lane_vld_o = '0;
      cnt_o      = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
         lane_vld_o[k] = |onehot_o[k];
         cnt_o         = cnt_o + CW'(lane_vld_o[k]);
      end
   end

   // Beat is final once the remaining bits fit in one beat.
   always_comb begin
      pop = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         pop = pop + PW'(residual_q[i]);
      end
      last_o = (32'(pop) <= LANES);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         residual_q <= '0;
      end else begin
         state_q    <= state_d;
         residual_q <= residual_d;
      end
   end

   // Next state; a new vector may be taken on the final beat for gapless streaming.
   always_comb begin
      state_d    = state_q;
      residual_d = residual_q;
      vld_o      = 1'b0;
      rdy_o      = 1'b0;
      case (state_q)
         IDLE: begin
            rdy_o = 1'b1;
         end
         BUSY: begin
            vld_o = 1'b1;
            rdy_o = last_o & rdy_i;
            if (rdy_i) begin
               if (last_o) begin
                  state_d    = IDLE;
                  residual_d = '0;
               end else begin
                  residual_d = residual_q & ~issued;
               end
            end
         end
      endcase
      if (vld_i && rdy_o) begin
         state_d    = BUSY;
         residual_d = vect_i;
      end
   end

endmodule

// File: tb/tb_lib_decmps_seq.sv
// Bench for lib_decmps_seq: queue-based beat model checked every cycle, plus directed literal checks.
module tb_lib_decmps_seq;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned LANES = 4;
   localparam int unsigned CW    = 3;

   typedef logic [LANES-1:0][WIDTH-1:0] oh_t;
   typedef struct {
      oh_t oh_l;
      oh_t oh_m;
      int  cnt;
      bit  last;
   } beat_t;
   typedef beat_t bq_t[$];

   logic             clk;
   logic             rstn;
   logic [WIDTH-1:0] vect_i;
   logic             vld_i;
   logic             rdy_i;

   logic             rdy_o, vld_o, last_o;
   oh_t              onehot_o;
   logic [LANES-1:0] lane_vld_o;
   logic [CW-1:0]    cnt_o;

   logic             rdy_m, vld_m, last_m;
   oh_t              onehot_m;
   logic [LANES-1:0] lane_vld_m;
   logic [CW-1:0]    cnt_m;

   int n_chk;
   int n_fail;
   bq_t exp_q;

   lib_decmps_seq #(.WIDTH(WIDTH), .LANES(LANES), .LSB_MSB(0)) dut (
      .clk(clk), .rstn(rstn), .vect_i(vect_i), .vld_i(vld_i), .rdy_o(rdy_o),
      .onehot_o(onehot_o), .lane_vld_o(lane_vld_o), .cnt_o(cnt_o),
      .vld_o(vld_o), .rdy_i(rdy_i), .last_o(last_o)
   );

   lib_decmps_seq #(.WIDTH(WIDTH), .LANES(LANES), .LSB_MSB(1)) dut_m (
      .clk(clk), .rstn(rstn), .vect_i(vect_i), .vld_i(vld_i), .rdy_o(rdy_m),
      .onehot_o(onehot_m), .lane_vld_o(lane_vld_m), .cnt_o(cnt_m),
      .vld_o(vld_m), .rdy_i(rdy_i), .last_o(last_m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected beats for one vector: list set-bit positions, chunk them LANES at a time.
   function automatic bq_t model(input logic [WIDTH-1:0] v);
      bq_t q;
      int  idx[$];
      int  n;
      int  nb;
      for (int i = 0; i < int'(WIDTH); i++) if (v[i]) idx.push_back(i);
      n  = idx.size();
      nb = (n == 0) ? 1 : (n + int'(LANES) - 1) / int'(LANES);
      for (int b = 0; b < nb; b++) begin
         beat_t bt;
         bt.oh_l = '0;
         bt.oh_m = '0;
         bt.cnt  = 0;
         for (int k = 0; k < int'(LANES); k++) begin
            int j;
            j = b * int'(LANES) + k;
            if (j < n) begin
               bt.oh_l[k][idx[j]]       = 1'b1;
               bt.oh_m[k][idx[n-1-j]]   = 1'b1;
               bt.cnt++;
            end
         end
         bt.last = (b == nb - 1);
         q.push_back(bt);
      end
      return q;
   endfunction

   function automatic logic [LANES-1:0] lv_of(input oh_t o);
      logic [LANES-1:0] r;
      for (int k = 0; k < int'(LANES); k++) r[k] = |o[k];
      return r;
   endfunction

   // Per-cycle compare against the model, then advance the model on observed handshakes.
   always @(negedge clk) begin
      bit    busy;
      bit    rdy_e;
      beat_t b;
      bq_t   nq;
      if (!rstn) begin
         exp_q.delete();
         chk("rst_vld",    64'(vld_o),      64'(0));
         chk("rst_rdy",    64'(rdy_o),      64'(1));
         chk("rst_last",   64'(last_o),     64'(1));
         chk("rst_cnt",    64'(cnt_o),      64'(0));
         chk("rst_lanevld",64'(lane_vld_o), 64'(0));
         chk("rst_onehot", 64'(onehot_o),   64'(0));
         chk("rst_vld_m",  64'(vld_m),      64'(0));
         chk("rst_oh_m",   64'(onehot_m),   64'(0));
      end else begin
         busy  = (exp_q.size() != 0);
         rdy_e = !busy || (exp_q[0].last && rdy_i);
         chk("vld_o",   64'(vld_o), 64'(busy));
         chk("rdy_o",   64'(rdy_o), 64'(rdy_e));
         chk("vld_m",   64'(vld_m), 64'(busy));
         chk("rdy_m",   64'(rdy_m), 64'(rdy_e));
         if (busy) begin
            b = exp_q[0];
            chk("onehot",   64'(onehot_o),   64'(b.oh_l));
            chk("lane_vld", 64'(lane_vld_o), 64'(lv_of(b.oh_l)));
            chk("cnt",      64'(cnt_o),      64'(b.cnt));
            chk("last",     64'(last_o),     64'(b.last));
            chk("onehot_m", 64'(onehot_m),   64'(b.oh_m));
            chk("lane_vld_m", 64'(lane_vld_m), 64'(lv_of(b.oh_m)));
            chk("cnt_m",    64'(cnt_m),      64'(b.cnt));
            chk("last_m",   64'(last_m),     64'(b.last));
         end
         if (busy && rdy_i) void'(exp_q.pop_front());
         if (vld_i && rdy_e) begin
            nq = model(vect_i);
            foreach (nq[i]) exp_q.push_back(nq[i]);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         if (!vld_o) break;
         step();
      end
      chk("idle_reached", 64'(vld_o), 64'(0));
   endtask

   initial begin
      bq_t m;
      logic [WIDTH-1:0] vecs [6];
      int cyc;
      bit acc;

      n_chk  = 0;
      n_fail = 0;
      rstn   = 1'b0;
      vld_i  = 1'b0;
      vect_i = '0;
      rdy_i  = 1'b1;

      // Pin the model with hand-computed values.
      m = model(16'h00A5);
      chk("model_a5_n",  64'(m.size()), 64'(1));
      chk("model_a5_oh", 64'(m[0].oh_l), 64'h0080_0020_0004_0001);
      m = model(16'hFFFF);
      chk("model_ff_n",  64'(m.size()), 64'(4));
      chk("model_ff_b4", 64'(m[3].oh_l), 64'h8000_4000_2000_1000);
      m = model(16'h8001);
      chk("model_msb",   64'(m[0].oh_m), 64'h0000_0000_0001_8000);
      m = model(16'h0000);
      chk("model_zero",  64'({m.size() == 1, m[0].cnt == 0, m[0].last}), 64'b111);

      repeat (3) step();
      rstn = 1'b1;
      step();

      // Single-beat vector.
      vld_i = 1'b1; vect_i = 16'h00A5; step(); vld_i = 1'b0;
      chk("a5_oh",   64'(onehot_o), 64'h0080_0020_0004_0001);
      chk("a5_cnt",  64'(cnt_o), 64'(4));
      chk("a5_last", 64'(last_o), 64'(1));
      wait_idle();

      // Full vector, four beats.
      vld_i = 1'b1; vect_i = 16'hFFFF; step(); vld_i = 1'b0;
      chk("ff_b1", 64'(onehot_o), 64'h0008_0004_0002_0001);
      chk("ff_b1_cnt", 64'(cnt_o), 64'(4));
      step(); step(); step();
      chk("ff_b4", 64'(onehot_o), 64'h8000_4000_2000_1000);
      chk("ff_b4_last", 64'(last_o), 64'(1));
      step();
      chk("ff_done", 64'(vld_o), 64'(0));

      // Zero vector.
      vld_i = 1'b1; vect_i = 16'h0000; step(); vld_i = 1'b0;
      chk("z_vld", 64'(vld_o), 64'(1));
      chk("z_lv",  64'(lane_vld_o), 64'(0));
      chk("z_cnt", 64'(cnt_o), 64'(0));
      chk("z_last", 64'(last_o), 64'(1));
      step();
      chk("z_idle", 64'(vld_o), 64'(0));

      // Backpressure hold.
      rdy_i = 1'b0;
      vld_i = 1'b1; vect_i = 16'h0301; step(); vld_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk("hold_oh",  64'(onehot_o), 64'h0000_0200_0100_0001);
         chk("hold_lv",  64'(lane_vld_o), 64'b0111);
         chk("hold_rdy", 64'(rdy_o), 64'(0));
         if (c < 2) step();
         else begin
            step();
            rdy_i = 1'b1;
            #1;
            chk("hold_rel_rdy", 64'(rdy_o), 64'(1));
         end
      end
      step();
      chk("hold_done", 64'(vld_o), 64'(0));

      // Back-to-back vectors with vld_i held.
      vld_i = 1'b1; vect_i = 16'h001F; step(); vect_i = 16'h0003;
      chk("bb_b1", 64'(onehot_o), 64'h0008_0004_0002_0001);
      chk("bb_b1_rdy", 64'(rdy_o), 64'(0));
      step();
      chk("bb_b2", 64'(onehot_o), 64'h0000_0000_0000_0010);
      chk("bb_b2_rdy", 64'(rdy_o), 64'(1));
      step(); vld_i = 1'b0;
      chk("bb_b3_vld", 64'(vld_o), 64'(1));
      chk("bb_b3", 64'(onehot_o), 64'h0000_0000_0002_0001);
      step();
      chk("bb_idle", 64'(vld_o), 64'(0));

      // MSB-first order.
      vld_i = 1'b1; vect_i = 16'h8001; step(); vld_i = 1'b0;
      chk("msb_oh", 64'(onehot_m), 64'h0000_0000_0001_8000);
      chk("lsb_oh", 64'(onehot_o), 64'h0000_0000_8000_0001);
      wait_idle();

      // Streaming with irregular downstream readiness.
      vecs = '{16'h8000, 16'h0F0F, 16'h1111, 16'hAAAA, 16'h0007, 16'hFFFE};
      cyc = 0;
      foreach (vecs[v]) begin
         vld_i = 1'b1; vect_i = vecs[v];
         for (int t = 0; t < 100; t++) begin
            rdy_i = (cyc % 3) != 0;
            cyc++;
            #1;
            acc = rdy_o;
            step();
            if (acc) break;
         end
      end
      vld_i = 1'b0; rdy_i = 1'b1;
      wait_idle();

      // Reset during beat 2.
      vld_i = 1'b1; vect_i = 16'hFFFF; step(); vld_i = 1'b0;
      step();
      chk("rst_b2_vld_pre", 64'(vld_o), 64'(1));
      rstn = 1'b0;
      #1;
      chk("rst_b2_vld", 64'(vld_o), 64'(0));
      step(); step();
      rstn = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         chk("rst_no_beats", 64'(vld_o), 64'(0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
